// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32IM decode/control stage between fetch and
// execute. Decodes one instruction per accepted transfer into ALU, regfile and
// GPIO controls, holds them behind a valid/ready handshake, and stalls intake
// while the iterative multiplier in execute is still busy.
// Optional feature macro: ILLEGAL_TRAP_EN (sticky illegal-instruction trap).
module decode_ctrl_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter logic [11:0] GPIO_CSR   = 12'hF02
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            flush,
    output logic            ctrl_valid,
    input  logic            ctrl_ready,
    output logic            alusrc,
    output logic            regwrite,
    output logic [1:0]      regsel,
    output logic [3:0]      op,
    output logic            gpio_we,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm_out,
    output logic            illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_MULH = 4'b0110;
    localparam logic [3:0] ALU_MULHU= 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;

    typedef enum logic {RUN, MUL_WAIT} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;

    logic            ctrl_valid_q;
    logic            alusrc_q, alusrc_d;
    logic            regwrite_q, regwrite_d;
    logic [1:0]      regsel_q, regsel_d;
    logic [3:0]      op_q, op_d;
    logic            gpio_we_q, gpio_we_d;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0] imm_q;
    logic            illegal_q, illegal_d;
    logic [31:0]     imm32_d;
    logic            legal_d;
    logic            is_mul_d;
    logic            accept;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    // Combinational decode of the offered instruction; anything unmatched stays a NOP
    always_comb begin
        alusrc_d   = 1'b0;
        regwrite_d = 1'b0;
        regsel_d   = 2'b00;
        op_d       = ALU_AND;
        gpio_we_d  = 1'b0;
        imm32_d    = '0;
        legal_d    = 1'b0;
        is_mul_d   = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal_d = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: op_d = ALU_ADD;
                    {7'b0000000, 3'b001}: op_d = ALU_SLL;
                    {7'b0000000, 3'b010}: op_d = ALU_SLT;
                    {7'b0000000, 3'b011}: op_d = ALU_SLTU;
                    {7'b0000000, 3'b100}: op_d = ALU_XOR;
                    {7'b0000000, 3'b101}: op_d = ALU_SRL;
                    {7'b0000000, 3'b110}: op_d = ALU_OR;
                    {7'b0000000, 3'b111}: op_d = ALU_AND;
                    {7'b0100000, 3'b000}: op_d = ALU_SUB;
                    {7'b0100000, 3'b101}: op_d = ALU_SRA;
                    {7'b0000001, 3'b000}: begin op_d = ALU_MUL;   is_mul_d = 1'b1; end
                    {7'b0000001, 3'b001}: begin op_d = ALU_MULH;  is_mul_d = 1'b1; end
                    {7'b0000001, 3'b011}: begin op_d = ALU_MULHU; is_mul_d = 1'b1; end
                    default:              legal_d = 1'b0;
                endcase
                if (legal_d) begin
                    regwrite_d = 1'b1;
                    regsel_d   = 2'b10;
                end
            end
            OPC_OPIMM: begin
                imm32_d = {{20{instr_in[31]}}, instr_in[31:20]};
                case (funct3)
                    3'b000: begin legal_d = 1'b1; op_d = ALU_ADD; end
                    3'b100: begin legal_d = 1'b1; op_d = ALU_XOR; end
                    3'b110: begin legal_d = 1'b1; op_d = ALU_OR;  end
                    3'b111: begin legal_d = 1'b1; op_d = ALU_AND; end
                    3'b001: begin
                        imm32_d = {27'b0, instr_in[24:20]};
                        if (funct7 == 7'b0000000) begin legal_d = 1'b1; op_d = ALU_SLL; end
                    end
                    3'b101: begin
                        imm32_d = {27'b0, instr_in[24:20]};
                        if (funct7 == 7'b0000000) begin legal_d = 1'b1; op_d = ALU_SRL; end
                        else if (funct7 == 7'b0100000) begin legal_d = 1'b1; op_d = ALU_SRA; end
                    end
                    default: ;
                endcase
                if (legal_d) begin
                    alusrc_d   = 1'b1;
                    regwrite_d = 1'b1;
                    regsel_d   = 2'b10;
                end else begin
                    imm32_d = '0;
                end
            end
            OPC_LUI: begin
                legal_d    = 1'b1;
                regwrite_d = 1'b1;
                regsel_d   = 2'b01;
                imm32_d    = {instr_in[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b001) begin
                    legal_d    = 1'b1;
                    regsel_d   = 2'b11;
                    regwrite_d = (instr_in[11:7] != 5'd0);
                    gpio_we_d  = (instr_in[31:20] == GPIO_CSR);
                end
            end
            default: ;
        endcase
        illegal_d = TRAP_EN && !legal_d;
    end

    // A trapped illegal instruction keeps intake closed until rst or flush
    assign instr_ready = (state_q == RUN) && (!ctrl_valid_q || ctrl_ready) && !flush && !illegal_q;
    assign accept      = instr_valid && instr_ready;

    // Output register: load on accept, drop valid on consume, flush discards
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_valid_q <= 1'b0;
            alusrc_q     <= 1'b0;
            regwrite_q   <= 1'b0;
            regsel_q     <= '0;
            op_q         <= '0;
            gpio_we_q    <= 1'b0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            illegal_q    <= 1'b0;
        end else if (flush) begin
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (accept) begin
            ctrl_valid_q <= 1'b1;
            alusrc_q     <= alusrc_d;
            regwrite_q   <= regwrite_d;
            regsel_q     <= regsel_d;
            op_q         <= op_d;
            gpio_we_q    <= gpio_we_d;
            rd_q         <= instr_in[11:7];
            rs1_q        <= instr_in[19:15];
            rs2_q        <= instr_in[24:20];
            imm_q        <= XLEN'($signed(imm32_d));
            illegal_q    <= illegal_d;
        end else if (ctrl_ready) begin
            ctrl_valid_q <= 1'b0;
        end
    end

    // Multiplier occupancy FSM: stays in MUL_WAIT for MUL_CYCLES-1 cycles after a mul issue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept && is_mul_d && (MUL_CYCLES > 1)) begin
                        state_q <= MUL_WAIT;
                        cnt_q   <= CW'(MUL_CYCLES - 1);
                    end
                end
                MUL_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ctrl_valid = ctrl_valid_q;
    assign alusrc     = alusrc_q;
    assign regwrite   = regwrite_q;
    assign regsel     = regsel_q;
    assign op         = op_q;
    assign gpio_we    = gpio_we_q;
    assign rd         = rd_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign imm_out    = imm_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: a driver issues directed and random
// instructions, predicts acceptance and decoded controls from an instruction
// table, and queues expected transfers; a monitor compares them when presented.
module tb_decode_ctrl_stage;

    localparam int unsigned MULC = 4;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_in = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        flush = 1'b0;
    logic        ctrl_valid;
    logic        ctrl_ready = 1'b0;
    logic        alusrc, regwrite, gpio_we, illegal;
    logic [1:0]  regsel;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_out;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.XLEN(32), .MUL_CYCLES(MULC), .GPIO_CSR(12'hF02)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flush(flush), .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready), .alusrc(alusrc), .regwrite(regwrite),
        .regsel(regsel), .op(op), .gpio_we(gpio_we), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm_out(imm_out), .illegal(illegal)
    );

    typedef struct packed {
        logic        alusrc;
        logic        regwrite;
        logic [1:0]  regsel;
        logic [3:0]  op;
        logic        gpio_we;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
        logic        mul;
    } exp_t;

    // kind: 0 reg-reg, 1 imm arith, 2 shift imm, 3 lui, 4 csrrw
    typedef struct packed {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       uf3;
        logic       uf7;
        logic [2:0] kind;
        logic [3:0] op;
        logic       mul;
    } ent_t;

    localparam int NENT = 22;
    ent_t tbl [NENT];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    bit   m_valid = 1'b0;
    bit   m_ill   = 1'b0;
    int   m_busy  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic uf3, input logic uf7, input logic [2:0] kind,
                                input logic [3:0] op, input logic mul);
        ent_t e;
        e.opc = opc; e.f3 = f3; e.f7 = f7; e.uf3 = uf3; e.uf7 = uf7;
        e.kind = kind; e.op = op; e.mul = mul;
        return e;
    endfunction

    task automatic init_tbl();
        tbl[0]  = mk(7'b0110011, 3'b000, 7'b0000000, 1, 1, 0, 4'h3, 0); // add
        tbl[1]  = mk(7'b0110011, 3'b000, 7'b0100000, 1, 1, 0, 4'h4, 0); // sub
        tbl[2]  = mk(7'b0110011, 3'b001, 7'b0000000, 1, 1, 0, 4'h8, 0); // sll
        tbl[3]  = mk(7'b0110011, 3'b010, 7'b0000000, 1, 1, 0, 4'hC, 0); // slt
        tbl[4]  = mk(7'b0110011, 3'b011, 7'b0000000, 1, 1, 0, 4'hD, 0); // sltu
        tbl[5]  = mk(7'b0110011, 3'b100, 7'b0000000, 1, 1, 0, 4'h2, 0); // xor
        tbl[6]  = mk(7'b0110011, 3'b101, 7'b0000000, 1, 1, 0, 4'h9, 0); // srl
        tbl[7]  = mk(7'b0110011, 3'b101, 7'b0100000, 1, 1, 0, 4'hA, 0); // sra
        tbl[8]  = mk(7'b0110011, 3'b110, 7'b0000000, 1, 1, 0, 4'h1, 0); // or
        tbl[9]  = mk(7'b0110011, 3'b111, 7'b0000000, 1, 1, 0, 4'h0, 0); // and
        tbl[10] = mk(7'b0110011, 3'b000, 7'b0000001, 1, 1, 0, 4'h5, 1); // mul
        tbl[11] = mk(7'b0110011, 3'b001, 7'b0000001, 1, 1, 0, 4'h6, 1); // mulh
        tbl[12] = mk(7'b0110011, 3'b011, 7'b0000001, 1, 1, 0, 4'h7, 1); // mulhu
        tbl[13] = mk(7'b0010011, 3'b000, 7'b0000000, 1, 0, 1, 4'h3, 0); // addi
        tbl[14] = mk(7'b0010011, 3'b100, 7'b0000000, 1, 0, 1, 4'h2, 0); // xori
        tbl[15] = mk(7'b0010011, 3'b110, 7'b0000000, 1, 0, 1, 4'h1, 0); // ori
        tbl[16] = mk(7'b0010011, 3'b111, 7'b0000000, 1, 0, 1, 4'h0, 0); // andi
        tbl[17] = mk(7'b0010011, 3'b001, 7'b0000000, 1, 1, 2, 4'h8, 0); // slli
        tbl[18] = mk(7'b0010011, 3'b101, 7'b0000000, 1, 1, 2, 4'h9, 0); // srli
        tbl[19] = mk(7'b0010011, 3'b101, 7'b0100000, 1, 1, 2, 4'hA, 0); // srai
        tbl[20] = mk(7'b0110111, 3'b000, 7'b0000000, 0, 0, 3, 4'h0, 0); // lui
        tbl[21] = mk(7'b1110011, 3'b001, 7'b0000000, 1, 0, 4, 4'h0, 0); // csrrw
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        bit   hit = 1'b0;
        e     = '0;
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        for (int k = 0; k < NENT; k++) begin
            if (!hit && w[6:0] == tbl[k].opc && (!tbl[k].uf3 || w[14:12] == tbl[k].f3)
                && (!tbl[k].uf7 || w[31:25] == tbl[k].f7)) begin
                hit   = 1'b1;
                e.op  = tbl[k].op;
                e.mul = tbl[k].mul;
                case (tbl[k].kind)
                    3'd0: begin e.regwrite = 1; e.regsel = 2'b10; end
                    3'd1: begin e.alusrc = 1; e.regwrite = 1; e.regsel = 2'b10;
                                e.imm = {{20{w[31]}}, w[31:20]}; end
                    3'd2: begin e.alusrc = 1; e.regwrite = 1; e.regsel = 2'b10;
                                e.imm = {27'b0, w[24:20]}; end
                    3'd3: begin e.regwrite = 1; e.regsel = 2'b01; e.imm = {w[31:12], 12'b0}; end
                    default: begin e.regsel = 2'b11; e.regwrite = (w[11:7] != 0);
                                   e.gpio_we = (w[31:20] == 12'hF02); end
                endcase
            end
        end
        if (!hit) e.illegal = TRAP;
        return e;
    endfunction

    function automatic logic [63:0] pack_exp(input exp_t e);
        return {7'b0, e.alusrc, e.regwrite, e.regsel, e.op, e.gpio_we, e.rd, e.rs1, e.rs2, e.imm, e.illegal};
    endfunction

    function automatic logic [63:0] pack_dut();
        return {7'b0, alusrc, regwrite, regsel, op, gpio_we, rd, rs1, rs2, imm_out, illegal};
    endfunction

    // One clock of stimulus: predict acceptance, then update the model after the edge
    task automatic cycle(input bit iv, input logic [31:0] w, input bit cr, input bit fl);
        bit   er, acc;
        exp_t e;
        instr_valid = iv; instr_in = w; ctrl_ready = cr; flush = fl;
        er  = (m_busy == 0) && (!m_valid || cr) && !fl && !m_ill;
        acc = iv && er;
        #1;
        check("instr_ready", 64'(instr_ready), 64'(er));
        @(posedge clk);
        #1;
        if (fl) begin
            if (m_valid && !cr && q.size() > 0) void'(q.pop_front());
            m_valid = 0; m_busy = 0; m_ill = 0;
        end else if (acc) begin
            e = ref_decode(w);
            q.push_back(e);
            m_valid = 1;
            if (e.mul && MULC > 1) m_busy = MULC - 1;
            if (e.illegal) m_ill = 1;
        end else begin
            if (cr) m_valid = 0;
            if (m_busy > 0) m_busy--;
        end
        check("ctrl_valid", 64'(ctrl_valid), 64'(m_valid));
    endtask

    task automatic do_reset();
        rst = 1; instr_valid = 0; flush = 0; ctrl_ready = 0; instr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        m_valid = 0; m_busy = 0; m_ill = 0;
        check("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
        check("rst_outputs", pack_dut(), 64'd0);
        #1;
        check("rst_instr_ready", 64'(instr_ready), 64'd1);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          r, k;
        r = $urandom_range(0, 9);
        w = $urandom;
        if (r < 7) begin
            k = $urandom_range(0, NENT - 1);
            w[6:0] = tbl[k].opc;
            if (tbl[k].uf3) w[14:12] = tbl[k].f3;
            if (tbl[k].uf7) w[31:25] = tbl[k].f7;
            if (tbl[k].kind == 3'd4 && $urandom_range(0, 1) == 1) w[31:20] = 12'hF02;
        end else if (r == 7) begin
            w = 32'hFFFF_FFFF;
        end
        return w;
    endfunction

    // Monitor: every presented output must match the oldest pending transfer
    initial begin
        forever begin
            @(negedge clk);
            if (rst == 1'b0 && ctrl_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_valid: ctrl_valid=1 required no pending output at %0t", $time);
                end else begin
                    check("ctrl_fields", pack_dut(), pack_exp(q[0]));
                    if (ctrl_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_tbl();
        do_reset();
        // addi x1,x0,5
        cycle(1, 32'h0050_0093, 1, 0);
        // add then sub back-to-back
        cycle(1, 32'h0020_81B3, 1, 0);
        cycle(1, 32'h4020_81B3, 1, 0);
        // mul followed by add: intake stalls for MULC-1 cycles
        cycle(1, 32'h0220_81B3, 1, 0);
        repeat (5) cycle(1, 32'h0020_81B3, 1, 0);
        // lui held for 3 cycles
        cycle(1, 32'h1234_52B7, 0, 0);
        repeat (3) cycle(0, 32'h0, 0, 0);
        cycle(0, 32'h0, 1, 0);
        // csrrw x0,0xF02,x6
        cycle(1, 32'hF023_1073, 1, 0);
        // flush during multiplier wait
        cycle(1, 32'h0220_81B3, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 1);
        cycle(1, 32'h0050_0093, 1, 0);
        // flush while output held and not consumed
        cycle(1, 32'h0050_0093, 0, 0);
        cycle(0, 32'h0, 0, 1);
        // reset in the middle of a multiplier wait
        cycle(1, 32'h0220_81B3, 1, 0);
        cycle(0, 32'h0, 1, 0);
        do_reset();
        // all-ones encoding, then attempts to issue, then flush
        cycle(1, 32'hFFFF_FFFF, 1, 0);
        repeat (3) cycle(1, 32'h0050_0093, 1, 0);
        cycle(0, 32'h0, 1, 1);
        cycle(1, 32'h0050_0093, 1, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 9) < 8, gen_instr(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3);
        end
        repeat (4) cycle(0, 32'h0, 1, 0);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
